// File: rtl/ili9341_window_seq.sv
// ILI9341 8-bit write-bus sequencer: CASET/PASET/RAMWR header, then RGB565 pixels MSB first.
// Optional solid-fill source enabled by defining ILI9341_WINDOW_FILL_EN (adds fill/fill_color).
module ili9341_window_seq #(
  parameter int WR_HALF    = 1,
  parameter int MAX_PIXELS = 76800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [8:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        cmd_data,
  output logic        write_edge,
`ifdef ILI9341_WINDOW_FILL_EN
  input  logic        fill,
  input  logic [15:0] fill_color,
`endif
  output logic [7:0]  dout
);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_PIX_HI, S_PIX_LO, S_FIN} state_t;

  state_t      state_q, state_d;
  logic        ph_q, ph_d;
  logic [3:0]  tmr_q, tmr_d, idx_q, idx_d;
  logic [16:0] cnt_q, cnt_d;
  logic [15:0] pix_q, pix_d;
  logic [8:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic        rej_q, rej_d, cd_q, cd_d;
  logic [7:0]  dout_q, dout_d;

  logic        bad, in_cell, cell_end, use_fill;
  logic [9:0]  cols, rows;
  logic [19:0] area;
  logic [16:0] cnt_load;
  logic [8:0]  hdr_b, cur_b;
  logic [15:0] fill_px;

`ifdef ILI9341_WINDOW_FILL_EN
  logic        fill_q;
  logic [15:0] fcol_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= 1'b0;
      fcol_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      fill_q <= fill;
      fcol_q <= fill_color;
    end
  end
  assign use_fill = fill_q;
  assign fill_px  = fcol_q;
`else
  assign use_fill = 1'b0;
  assign fill_px  = '0;
`endif

  // Window validation and pixel count, evaluated on the live inputs at start
  always_comb begin
    bad      = (x1 < x0) || (y1 < y0) || (x1 > 9'd319) || (y1 > 9'd319);
    cols     = {1'b0, x1} - {1'b0, x0} + 10'd1;
    rows     = {1'b0, y1} - {1'b0, y0} + 10'd1;
    area     = 20'(cols) * 20'(rows);
    cnt_load = (area > 20'(MAX_PIXELS)) ? 17'(MAX_PIXELS) : area[16:0];
  end

  // Header byte table: {cmd_data, byte}
  always_comb begin
    hdr_b = {1'b0, 8'h2C};
    case (idx_q)
      4'd0:    hdr_b = {1'b0, 8'h2A};
      4'd1:    hdr_b = {1'b1, 7'd0, x0_q[8]};
      4'd2:    hdr_b = {1'b1, x0_q[7:0]};
      4'd3:    hdr_b = {1'b1, 7'd0, x1_q[8]};
      4'd4:    hdr_b = {1'b1, x1_q[7:0]};
      4'd5:    hdr_b = {1'b0, 8'h2B};
      4'd6:    hdr_b = {1'b1, 7'd0, y0_q[8]};
      4'd7:    hdr_b = {1'b1, y0_q[7:0]};
      4'd8:    hdr_b = {1'b1, 7'd0, y1_q[8]};
      4'd9:    hdr_b = {1'b1, y1_q[7:0]};
      default: hdr_b = {1'b0, 8'h2C};
    endcase
  end

  always_comb begin
    state_d = state_q; ph_d = ph_q; tmr_d = tmr_q; idx_d = idx_q;
    cnt_d = cnt_q; pix_d = pix_q; rej_d = rej_q;
    x0_d = x0_q; x1_d = x1_q; y0_d = y0_q; y1_d = y1_q;

    in_cell  = (state_q == S_HDR) || (state_q == S_PIX_HI) || (state_q == S_PIX_LO);
    cell_end = in_cell && ph_q && (tmr_q == 4'(WR_HALF - 1));

    // Outside a byte cell the bus keeps its last byte, so stalls cause no activity
    case (state_q)
      S_HDR:    cur_b = hdr_b;
      S_PIX_HI: cur_b = {1'b1, pix_q[15:8]};
      S_PIX_LO: cur_b = {1'b1, pix_q[7:0]};
      default:  cur_b = {cd_q, dout_q};
    endcase
    cd_d       = cur_b[8];
    dout_d     = cur_b[7:0];
    cmd_data   = cur_b[8];
    dout       = cur_b[7:0];
    write_edge = in_cell && ph_q;
    busy       = in_cell || (state_q == S_FETCH);
    done       = (state_q == S_FIN);
    err        = (state_q == S_FIN) && rej_q;
    pix_ready  = (state_q == S_FETCH) && !use_fill;

    if (in_cell) begin
      if (tmr_q == 4'(WR_HALF - 1)) begin
        tmr_d = 4'd0;
        ph_d  = ~ph_q;
      end else begin
        tmr_d = tmr_q + 4'd1;
      end
    end

    case (state_q)
      S_IDLE: if (start) begin
        x0_d = x0; x1_d = x1; y0_d = y0; y1_d = y1;
        rej_d = bad;
        cnt_d = cnt_load;
        idx_d = 4'd0; ph_d = 1'b0; tmr_d = 4'd0;
        state_d = bad ? S_FIN : S_HDR;
      end
      S_HDR: if (cell_end) begin
        if (idx_q == 4'd10) state_d = S_FETCH;
        else                idx_d   = idx_q + 4'd1;
      end
      S_FETCH: if (use_fill || pix_valid) begin
        pix_d   = use_fill ? fill_px : pix_data;
        cnt_d   = cnt_q - 17'd1;
        state_d = S_PIX_HI;
      end
      S_PIX_HI: if (cell_end) state_d = S_PIX_LO;
      S_PIX_LO: if (cell_end) state_d = (cnt_q == 17'd0) ? S_FIN : S_FETCH;
      S_FIN: begin
        rej_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; ph_q <= 1'b0; tmr_q <= '0; idx_q <= '0;
      cnt_q <= '0; pix_q <= '0; rej_q <= 1'b0; cd_q <= 1'b0; dout_q <= '0;
      x0_q <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0;
    end else begin
      state_q <= state_d; ph_q <= ph_d; tmr_q <= tmr_d; idx_q <= idx_d;
      cnt_q <= cnt_d; pix_q <= pix_d; rej_q <= rej_d; cd_q <= cd_d; dout_q <= dout_d;
      x0_q <= x0_d; x1_q <= x1_d; y0_q <= y0_d; y1_q <= y1_d;
    end
  end
endmodule

// File: doc/ili9341_window_seq.md
Name: ili9341_window_seq

Overview:
- Hardware sequencer for the ILI9341 8-bit parallel write bus (cmd_data / write_edge / dout).
- On a start pulse it issues CASET (0x2A) and PASET (0x2B) with the latched window, then RAMWR (0x2C).
- It then streams RGB565 pixels from a valid/ready source, two bytes per pixel, MSB first.
- Sits between the SoC pixel producers (playfield/sprite renderers, DMA) and the LCD pins, removing per-byte CPU writes.

Parameters:
- WR_HALF, 1: cycles write_edge is held low (dout stable) and then high, per byte. Range 1..15.
- MAX_PIXELS, 76800: saturation limit of the pixel count (320*240).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- x0  in  9  window start column
- x1  in  9  window end column (inclusive)
- y0  in  9  window start row
- y1  in  9  window end row (inclusive)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at sequence end
- err  out  1  one-cycle pulse with done when the window was rejected
- pix_valid  in  1  source has a pixel
- pix_data  in  16  RGB565 pixel
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- cmd_data  out  1  0 = command byte, 1 = data byte
- write_edge  out  1  LCD WR strobe; the display latches on the rising edge
- dout  out  8  LCD data bus

Behaviour:
- Reset values: busy=0, done=0, err=0, pix_ready=0, cmd_data=0, write_edge=0, dout=0x00, state=IDLE.
- Reset mid-sequence aborts immediately. No done pulse is issued; software must reissue the window.
- Start acceptance (IDLE): on start, latch x0, x1, y0, y1.
  - If x1<x0, y1<y0, x1>319 or y1>319, go to FIN with err. No bytes are written.
  - Otherwise load count = (x1-x0+1)*(y1-y0+1), saturated to MAX_PIXELS (17-bit), and go to HDR.
  - start while busy is ignored.
- Byte cell (shared by all byte emission):
  - Phase L: write_edge=0, dout and cmd_data driven with the byte for WR_HALF cycles.
  - Phase H: write_edge=1 for WR_HALF cycles, with dout and cmd_data held.
  - One byte takes 2*WR_HALF cycles; at WR_HALF=1, back-to-back bytes toggle write_edge every cycle.
- HDR: 11 bytes via a 4-bit index:
  - 0x2A (cmd), x0[15:8], x0[7:0], x1[15:8], x1[7:0] (data, coordinates zero-extended to 16 bits)
  - 0x2B (cmd), y0 hi, y0 lo, y1 hi, y1 lo (data)
  - 0x2C (cmd)
  - After the last byte's H phase, go to FETCH.
- FETCH: pix_ready=1, write_edge=0.
  - On the handshake, register pix_data, decrement count, and go to PIX_HI.
  - While pix_valid=0, stay in FETCH with write_edge low and dout unchanged (stall; no spurious edge).
- PIX_HI: byte cell with pix[15:8], cmd_data=1.
- PIX_LO: byte cell with pix[7:0], cmd_data=1. Then:
  - count==0 → FIN.
  - count!=0 → FETCH.
- pix_ready is asserted only in FETCH; at most one pixel is accepted per 2 bytes.
- FIN: write_edge=0, done=1 for one cycle (err also, if rejected), busy=0, then IDLE.
- Latency from start to the first write_edge rise is 1+WR_HALF cycles.
- Total cycles, no stalls: 1 + 11*2*WR_HALF + N*(1+4*WR_HALF) + 1.
- Window of exactly 1x1 is legal: 11 header bytes + 2 pixel bytes.

Optional Feature:
- Macro: ILI9341_WINDOW_FILL_EN.
- With the macro:
  - Extra ports fill (in, 1, sampled with start) and fill_color (in, 16, latched at start).
  - When fill=1, FETCH takes fill_color without a handshake (pix_ready stays 0) and takes 1 cycle, for solid clears/rectangles.
- Without the macro: ports absent; all pixels come from pix_data.

Test Plan:
- Reset, then start with x0=0, x1=0, y0=0, y1=0, WR_HALF=1, pix_data=0xF800 always valid:
  - Bytes 2A,00,00,00,00,2B,00,00,00,00,2C,F8,00.
  - cmd_data=0 only on 2A, 2B, 2C.
  - Exactly 13 write_edge rises, then one done pulse.
- Window x0=10, x1=13, y0=5, y1=6 (8 pixels), source gives 0x1234 and deasserts pix_valid for 5 cycles between pixels 3 and 4:
  - 16 pixel bytes alternating 12,34.
  - write_edge stays 0 throughout the stall.
  - Exactly 8 handshakes.
- Start with x0=20, x1=10 → err and done pulse together 1 cycle later; zero write_edge rises; busy never stays high.
- Assert reset during pixel 2 of a 4-pixel window → next cycle write_edge=0, busy=0, pix_ready=0, no done; a fresh start completes normally.
- WR_HALF=3, 1x1 window → each byte is 3 cycles low then 3 high; dout stable across all 6; a second start pulse mid-sequence is ignored.
- Build with ILI9341_WINDOW_FILL_EN, fill=1, fill_color=0x07E0, window 0..319 x 0..239 → 76800 pixel byte pairs 07,E0; pix_ready never asserted; done once.
